// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS control unit with mem_ready handshake and timeout watchdog; ADDI_SUPPORT_EN adds addi states
module multicycle_control_fsm #(
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               mem_error,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
    EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_wait, timeout;
  // state register and wait counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // next state, datapath controls, wait counting and watchdog abort
  always_comb begin
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    mem_wait   = 1'b0;
    state_d    = FETCH;
    case (state_q)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        mem_wait = 1'b1;
        state_d  = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          6'b000000:            state_d = EXEC;
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000100:            state_d = BRANCH;
          6'b000010:            state_d = JUMP;
`ifdef ADDI_SUPPORT_EN
          6'b001000:            state_d = ADDI_EXEC;
`endif
          default:              illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == 6'b100011) ? MEMRD : (Op == 6'b101011) ? MEMWR : FETCH;
      end
      MEMRD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        mem_wait = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        mem_wait = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef ADDI_SUPPORT_EN
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: RegWrite = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
    timeout   = mem_wait && !mem_ready && (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));
    mem_error = timeout;
    state_d   = timeout ? FETCH : state_d;
    cnt_d     = (mem_wait && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
    state     = reset ? '0 : state_q;
    if (reset) begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSource   = 2'b00;
      illegal_op = 1'b0;
      mem_error  = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random instruction stream checked against a per-instruction phase model
module tb_multicycle_control_fsm;
  localparam int T = 3;
  logic clk = 1'b0, reset;
  logic [5:0] Op;
  logic mem_ready;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic illegal_op, mem_error;
  logic [3:0] state;
  logic [17:0] obs;
  typedef struct {logic [3:0] st; logic rdy; logic err; logic ill;} ent_t;
  ent_t q[$];
  logic [5:0] cur_op;
  int total = 0, bad = 0;

  multicycle_control_fsm #(.STATE_W(4), .MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_error(mem_error), .state(state)
  );

  always #5 clk = ~clk;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_error};

  function automatic logic [17:0] exp_ctrl(ent_t e);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (e.st)
      4'd0: begin mr = 1; asb = 2'b01; irw = e.rdy; pcw = e.rdy; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, e.ill, e.err};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic err, input logic ill);
    ent_t e;
    e.st = st; e.rdy = rdy; e.err = err; e.ill = ill;
    q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // a memory phase with w wait cycles: completes after w stalls, or aborts once T stalls have elapsed
  task automatic mem_phase(input logic [3:0] st, input int w, output bit to);
    to = (w > T);
    for (int i = 0; i < (to ? T : w); i++) push(st, 1'b0, 1'b0, 1'b0);
    push(st, !to, to, 1'b0);
  endtask

  task automatic build(input logic [5:0] op, input int wf, input int wm);
    bit to;
    q.delete();
    cur_op = op;
    mem_phase(4'd0, wf, to);
    if (to) mem_phase(4'd0, 0, to);
    case (op)
      6'b000000: begin push(4'd1, rnd(), 0, 0); push(4'd6, rnd(), 0, 0); push(4'd7, rnd(), 0, 0); end
      6'b100011: begin
        push(4'd1, rnd(), 0, 0); push(4'd2, rnd(), 0, 0);
        mem_phase(4'd3, wm, to);
        if (!to) push(4'd4, rnd(), 0, 0);
      end
      6'b101011: begin push(4'd1, rnd(), 0, 0); push(4'd2, rnd(), 0, 0); mem_phase(4'd5, wm, to); end
      6'b000100: begin push(4'd1, rnd(), 0, 0); push(4'd8, rnd(), 0, 0); end
      6'b000010: begin push(4'd1, rnd(), 0, 0); push(4'd9, rnd(), 0, 0); end
`ifdef ADDI_SUPPORT_EN
      6'b001000: begin push(4'd1, rnd(), 0, 0); push(4'd10, rnd(), 0, 0); push(4'd11, rnd(), 0, 0); end
`endif
      default: push(4'd1, rnd(), 0, 1);
    endcase
  endtask

  task automatic check(input ent_t e, input int i);
    logic [17:0] x;
    x = exp_ctrl(e);
    total += 2;
    assert (state === e.st) else begin
      bad++;
      $error("FAIL state op=%b step=%0d got=%0d exp=%0d", cur_op, i, state, e.st);
    end
    assert (obs === x) else begin
      bad++;
      $error("FAIL ctrl op=%b step=%0d st=%0d got=%b exp=%b", cur_op, i, e.st, obs, x);
    end
  endtask

  task automatic check_zero(input string tag);
    total += 2;
    assert (state === 4'd0) else begin
      bad++;
      $error("FAIL %s_state got=%0d exp=0", tag, state);
    end
    assert (obs === 18'd0) else begin
      bad++;
      $error("FAIL %s_ctrl got=%b exp=0", tag, obs);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      Op = cur_op;
      mem_ready = q[i].rdy;
      #1;
      check(q[i], i);
      @(negedge clk);
    end
  endtask

  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    build(op, wf, wm);
    run(q.size());
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111, 6'b010101};
    reset = 1'b1;
    Op = 6'b100011;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    reset = 1'b0;
    instr(6'b000000, 0, 0);
    instr(6'b100011, 0, 2);
    instr(6'b000100, 0, 0);
    instr(6'b000010, 0, 0);
    instr(6'b101011, 0, 5);
    instr(6'b111111, 0, 0);
    instr(6'b001000, 0, 0);
    instr(6'b000000, 4, 0);
    instr(6'b100011, 0, 3);
    instr(6'b101011, 1, 4);
    instr(6'b101011, 2, 0);
    build(6'b100011, 0, 2);
    run(4);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    #1;
    check_zero("midreset_hold");
    reset = 1'b0;
    for (int k = 0; k < 80; k++)
      instr(ops[$urandom_range(0, 7)], $urandom_range(0, 4), $urandom_range(0, 5));
    for (int k = 0; k < 10; k++)
      instr(6'($urandom), $urandom_range(0, 4), $urandom_range(0, 5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
